// File: rtl/icap_pkg.sv
// Shared types and helpers for the ICAP configuration stream path.
// Optional macro ICAP_BITSWAP_EN selects the per-byte bit reversal in icap_stream_ctrl.
package icap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic ICAP_WRITE = 1'b0;

  // Reverses bit order inside each byte; narrower words use the low bytes.
  function automatic logic [31:0] bitswap_bytes(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[b*8 + i] = d[b*8 + 7 - i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; o_count reports the occupancy after the current edge.
module sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic push_ok, pop_ok;

  assign o_full    = (count_q == (AW+1)'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_count   = count_d;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && !i_flush && (!o_full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/icap_stream_ctrl.sv
// Buffers wide DDR beats and serialises them MS slice first into ICAP write words.
// Define ICAP_BITSWAP_EN to bit-reverse every byte of o_icap_data.
module icap_stream_ctrl
  import icap_pkg::*;
#(
  parameter int IN_W         = 256,
  parameter int OUT_W        = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [31:0]       i_word_count,
  input  logic              i_abort,
  input  logic [IN_W-1:0]   i_data,
  input  logic              i_data_valid,
  output logic              o_buff_full,
  output logic              o_icap_csib,
  output logic              o_icap_rdwrb,
  output logic [OUT_W-1:0]  o_icap_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_overflow,
  output logic [31:0]       o_words_sent
);

  localparam int SLICES = IN_W / OUT_W;
  localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
  localparam logic [SW-1:0] NEXT_AFTER_LOAD = (SLICES > 1) ? SW'(1) : SW'(0);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [SW-1:0]     idx_q, idx_d;
  logic [31:0]       target_q, target_d;
  logic [31:0]       words_q, words_d;
  logic              csib_q, csib_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              bfull_q, bfull_d;
  logic              busy_q, busy_d;

  logic              fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [IN_W-1:0]   fifo_rd_data;
  logic [CW-1:0]     fifo_count_nxt;
  logic [OUT_W-1:0]  cur_slice, slice_out;
  logic              last_word;

  // DMA handshake: i_data_valid is a write strobe with no ready; the engine must
  // honour o_buff_full, and a strobe that finds the FIFO full is dropped and flagged.
  sync_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_data_valid),
    .i_wr_data (i_data),
    .i_pop     (fifo_pop),
    .i_flush   (fifo_flush),
    .o_rd_data (fifo_rd_data),
    .o_count   (fifo_count_nxt),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  // LOAD emits the first slice straight from the FIFO head to meet the two-cycle start latency.
  assign cur_slice = (state_q == LOAD) ? fifo_rd_data[IN_W-1 -: OUT_W]
                                       : shreg_q[IN_W-1 -: OUT_W];
`ifdef ICAP_BITSWAP_EN
  assign slice_out = OUT_W'(bitswap_bytes(32'(cur_slice)));
`else
  assign slice_out = cur_slice;
`endif
  assign last_word = ((words_q + 32'd1) == target_q);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    target_d   = target_q;
    words_d    = words_q;
    csib_d     = 1'b1;
    data_d     = data_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
        end else if (i_start) begin
          if (i_word_count == 32'd0) begin
            done_d = 1'b1;
          end else begin
            target_d = i_word_count;
            words_d  = 32'd0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
          shreg_d    = '0;
          idx_d      = '0;
          state_d    = IDLE;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          csib_d   = 1'b0;
          data_d   = slice_out;
          words_d  = words_q + 32'd1;
          shreg_d  = fifo_rd_data << OUT_W;
          idx_d    = NEXT_AFTER_LOAD;
          if (last_word)        state_d = DONE;
          else if (SLICES == 1) state_d = LOAD;
          else                  state_d = STREAM;
        end
      end
      STREAM: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
          shreg_d    = '0;
          idx_d      = '0;
          state_d    = IDLE;
        end else begin
          csib_d  = 1'b0;
          data_d  = slice_out;
          words_d = words_q + 32'd1;
          shreg_d = shreg_q << OUT_W;
          idx_d   = idx_q + SW'(1);
          if (last_word) begin
            state_d = DONE;
          end else if (idx_q == LAST_SLICE) begin
            idx_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_rd_data;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        fifo_flush = 1'b1;
        shreg_d    = '0;
        idx_d      = '0;
        done_d     = !i_abort;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_d   = ovf_q | (i_data_valid & fifo_full & ~fifo_pop);
  assign bfull_d = (DEPTH - int'(fifo_count_nxt)) <= AFULL_MARGIN;
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      target_q <= '0;
      words_q  <= '0;
      csib_q   <= 1'b1;
      data_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bfull_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      words_q  <= words_d;
      csib_q   <= csib_d;
      data_q   <= data_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      bfull_q  <= bfull_d;
      busy_q   <= busy_d;
    end
  end

  assign o_buff_full    = bfull_q;
  assign o_icap_csib    = csib_q;
  assign o_icap_rdwrb   = ICAP_WRITE;
  assign o_icap_data    = data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err_overflow = ovf_q;
  assign o_words_sent   = words_q;

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// Directed bench for icap_stream_ctrl with a word-capture monitor and per-scenario checks.
// Build with ICAP_BITSWAP_EN defined to check the bit-reversed data path.
module tb_icap_stream_ctrl;

  localparam int IN_W  = 256;
  localparam int OUT_W = 32;
  localparam int DEPTH = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [31:0]       i_word_count = '0;
  logic              i_abort = 1'b0;
  logic [IN_W-1:0]   i_data = '0;
  logic              i_data_valid = 1'b0;
  logic              o_buff_full, o_icap_csib, o_icap_rdwrb, o_busy, o_done, o_err_overflow;
  logic [OUT_W-1:0]  o_icap_data;
  logic [31:0]       o_words_sent;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  logic [OUT_W-1:0] got_q[$];
  logic [OUT_W-1:0] exp_q[$];
  int got_cyc[$];

  icap_stream_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AFULL_MARGIN(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_word_count(i_word_count),
    .i_abort(i_abort), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_buff_full(o_buff_full), .o_icap_csib(o_icap_csib), .o_icap_rdwrb(o_icap_rdwrb),
    .o_icap_data(o_icap_data), .o_busy(o_busy), .o_done(o_done),
    .o_err_overflow(o_err_overflow), .o_words_sent(o_words_sent)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst && !o_icap_csib) begin
      got_q.push_back(o_icap_data);
      got_cyc.push_back(cyc);
    end
    if (!i_rst && o_done) done_cnt <= done_cnt + 1;
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [31:0] exp_word(input logic [31:0] v);
    logic [31:0] r;
    r = v;
`ifdef ICAP_BITSWAP_EN
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) r[8*b + i] = v[8*b + 7 - i];
`endif
    return r;
  endfunction

  function automatic logic [IN_W-1:0] make_beat(input logic [31:0] base);
    logic [IN_W-1:0] b;
    b = '0;
    for (int k = 0; k < IN_W/OUT_W; k++) b[IN_W-1-32*k -: 32] = base + 32'(k);
    return b;
  endfunction

  task automatic push_beat(input logic [IN_W-1:0] d);
    i_data = d;
    i_data_valid = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] cnt);
    i_word_count = cnt;
    i_start = 1'b1;
    start_cyc = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic clear_sb();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k = 0;
    while (o_busy === 1'b1 && k < max) begin
      @(negedge i_clk);
      k++;
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout busy=%b required 0 after %0d cycles", tag, o_busy, max);
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_data_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_icap_csib !== 1'b1) begin n_fail++; $display("FAIL rst_csib got %b required 1", o_icap_csib); end
    n_cmp++; if (o_icap_rdwrb !== 1'b0) begin n_fail++; $display("FAIL rst_rdwrb got %b required 0", o_icap_rdwrb); end
    n_cmp++; if (o_icap_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h required 0", o_icap_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b required 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b required 0", o_done); end
    n_cmp++; if (o_err_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b required 0", o_err_overflow); end
    n_cmp++; if (o_words_sent !== 32'd0) begin n_fail++; $display("FAIL rst_words got %0d required 0", o_words_sent); end
    n_cmp++; if (o_buff_full !== 1'b0) begin n_fail++; $display("FAIL rst_bfull got %b required 0", o_buff_full); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_full_transfer();
    int d0;
    logic [31:0] g;
    clear_sb();
    push_beat(make_beat(32'h0));
    push_beat(make_beat(32'h8));
    @(negedge i_clk);
    d0 = done_cnt;
    start_xfer(32'd16);
    wait_idle(60, "t1");
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_word(32'(i)));
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL t1_count got %0d required 16", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t1_word%0d got %h required %h", i, g, exp_q[i]); end
    end
    if (got_q.size() == 16) begin
      n_cmp++; if (got_cyc[0] - start_cyc != 2) begin n_fail++; $display("FAIL t1_latency got %0d required 2", got_cyc[0] - start_cyc); end
      n_cmp++; if (got_cyc[15] - got_cyc[0] != 15) begin n_fail++; $display("FAIL t1_contiguous got span %0d required 15", got_cyc[15] - got_cyc[0]); end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t1_done_pulses got %0d required 1", done_cnt - d0); end
    n_cmp++; if (o_words_sent !== 32'd16) begin n_fail++; $display("FAIL t1_words_sent got %0d required 16", o_words_sent); end
  endtask

  task automatic test_partial_discard();
    int d0;
    logic [31:0] g;
    clear_sb();
    push_beat(make_beat(32'h0));
    push_beat(make_beat(32'h8));
    push_beat(make_beat(32'h10));
    d0 = done_cnt;
    start_xfer(32'd12);
    wait_idle(60, "t2");
    for (int i = 0; i < 12; i++) exp_q.push_back(exp_word(32'(i)));
    n_cmp++; if (got_q.size() != 12) begin n_fail++; $display("FAIL t2_count got %0d required 12", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t2_word%0d got %h required %h", i, g, exp_q[i]); end
    end
    n_cmp++; if (o_words_sent !== 32'd12) begin n_fail++; $display("FAIL t2_words_sent got %0d required 12", o_words_sent); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t2_done_pulses got %0d required 1", done_cnt - d0); end
    // a leftover beat would show up ahead of the fresh one
    clear_sb();
    push_beat(make_beat(32'h200));
    start_xfer(32'd8);
    wait_idle(40, "t2b");
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_word(32'h200 + 32'(i)));
    n_cmp++; if (got_q.size() != 8) begin n_fail++; $display("FAIL t2_flush_count got %0d required 8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t2_flush_word%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_trickle();
    logic [31:0] g;
    clear_sb();
    start_xfer(32'd24);
    for (int b = 0; b < 3; b++) begin
      if (b == 1) start_xfer(32'd5);
      repeat (20) @(negedge i_clk);
      push_beat(make_beat(32'(8*b)));
    end
    wait_idle(60, "t3");
    for (int i = 0; i < 24; i++) exp_q.push_back(exp_word(32'(i)));
    n_cmp++; if (got_q.size() != 24) begin n_fail++; $display("FAIL t3_count got %0d required 24", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t3_word%0d got %h required %h", i, g, exp_q[i]); end
    end
    if (got_q.size() == 24) begin
      n_cmp++; if (got_cyc[8] - got_cyc[7] <= 1) begin n_fail++; $display("FAIL t3_gap1 got %0d required >1", got_cyc[8] - got_cyc[7]); end
      n_cmp++; if (got_cyc[16] - got_cyc[15] <= 1) begin n_fail++; $display("FAIL t3_gap2 got %0d required >1", got_cyc[16] - got_cyc[15]); end
      n_cmp++; if (got_cyc[7] - got_cyc[0] != 7) begin n_fail++; $display("FAIL t3_beat_span got %0d required 7", got_cyc[7] - got_cyc[0]); end
    end
    n_cmp++; if (o_words_sent !== 32'd24) begin n_fail++; $display("FAIL t3_words_sent got %0d required 24", o_words_sent); end
  endtask

  task automatic test_overflow();
    logic [31:0] g;
    do_reset();
    clear_sb();
    for (int k = 1; k <= 17; k++) begin
      push_beat(make_beat(32'(8*(k-1))));
      if (k == 13) begin
        n_cmp++; if (o_buff_full !== 1'b0) begin n_fail++; $display("FAIL t4_bfull13 got %b required 0", o_buff_full); end
      end
      if (k == 14) begin
        n_cmp++; if (o_buff_full !== 1'b1) begin n_fail++; $display("FAIL t4_bfull14 got %b required 1", o_buff_full); end
      end
      if (k == 16) begin
        n_cmp++; if (o_err_overflow !== 1'b0) begin n_fail++; $display("FAIL t4_ovf16 got %b required 0", o_err_overflow); end
      end
    end
    n_cmp++; if (o_err_overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf17 got %b required 1", o_err_overflow); end
    start_xfer(32'd128);
    wait_idle(300, "t4");
    for (int i = 0; i < 128; i++) exp_q.push_back(exp_word(32'(i)));
    n_cmp++; if (got_q.size() != 128) begin n_fail++; $display("FAIL t4_count got %0d required 128", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t4_word%0d got %h required %h", i, g, exp_q[i]); end
    end
    n_cmp++; if (o_err_overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf_sticky got %b required 1", o_err_overflow); end
    n_cmp++; if (o_buff_full !== 1'b0) begin n_fail++; $display("FAIL t4_bfull_drained got %b required 0", o_buff_full); end
  endtask

  task automatic test_abort();
    int d0;
    int k;
    logic [31:0] g;
    do_reset();
    clear_sb();
    push_beat(make_beat(32'h0));
    push_beat(make_beat(32'h8));
    d0 = done_cnt;
    start_xfer(32'd16);
    k = 0;
    while (o_words_sent !== 32'd5 && k < 40) begin
      @(negedge i_clk);
      k++;
    end
    n_cmp++; if (o_words_sent !== 32'd5) begin n_fail++; $display("FAIL t5_reach5 got %0d required 5", o_words_sent); end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    n_cmp++; if (o_icap_csib !== 1'b1) begin n_fail++; $display("FAIL t5_csib got %b required 1", o_icap_csib); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy got %b required 0", o_busy); end
    n_cmp++; if (o_words_sent !== 32'd5) begin n_fail++; $display("FAIL t5_words got %0d required 5", o_words_sent); end
    repeat (3) @(negedge i_clk);
    n_cmp++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL t5_no_done got %0d required 0", done_cnt - d0); end
    n_cmp++; if (got_q.size() != 5) begin n_fail++; $display("FAIL t5_emitted got %0d required 5", got_q.size()); end
    clear_sb();
    push_beat(make_beat(32'h300));
    start_xfer(32'd8);
    wait_idle(40, "t5b");
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_word(32'h300 + 32'(i)));
    n_cmp++; if (got_q.size() != 8) begin n_fail++; $display("FAIL t5_flush_count got %0d required 8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t5_flush_word%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_bitswap_and_zero();
    logic [IN_W-1:0] b;
    logic [31:0] e;
    clear_sb();
    b = '0;
    b[IN_W-1 -: 32] = 32'h01020380;
`ifdef ICAP_BITSWAP_EN
    e = 32'h8040C001;
`else
    e = 32'h01020380;
`endif
    push_beat(b);
    start_xfer(32'd1);
    wait_idle(20, "t6");
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL t6_count got %0d required 1", got_q.size()); end
    n_cmp++; if (got_q.size() < 1 || got_q[0] !== e) begin n_fail++; $display("FAIL t6_swap got %h required %h", (got_q.size() > 0) ? got_q[0] : 32'hx, e); end
    clear_sb();
    start_xfer(32'd0);
    n_cmp++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL t6_zero_done got %b required 1", o_done); end
    n_cmp++; if (o_icap_csib !== 1'b1) begin n_fail++; $display("FAIL t6_zero_csib got %b required 1", o_icap_csib); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL t6_zero_busy got %b required 0", o_busy); end
    @(negedge i_clk);
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL t6_zero_done_pulse got %b required 0", o_done); end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t6_zero_words got %0d required 0", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d0;
    push_beat(make_beat(32'h40));
    d0 = done_cnt;
    start_xfer(32'd8);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    n_cmp++; if (o_icap_csib !== 1'b1) begin n_fail++; $display("FAIL t7_csib got %b required 1", o_icap_csib); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL t7_busy got %b required 0", o_busy); end
    n_cmp++; if (o_words_sent !== 32'd0) begin n_fail++; $display("FAIL t7_words got %0d required 0", o_words_sent); end
    repeat (3) @(negedge i_clk);
    n_cmp++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL t7_no_done got %0d required 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_full_transfer();
    test_partial_discard();
    test_trickle();
    test_overflow();
    test_abort();
    test_bitswap_and_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
